// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - food box placement from a free-running LFSR, with score and speed tracking
module food_spawner #(
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          INIT_X    = 600,
   parameter int          INIT_Y    = 450,
   parameter int          X_MIN     = 20,
   parameter int          Y_MIN     = 20,
   parameter int          X_SLOTS   = 153,
   parameter int          Y_SLOTS   = 97,
   parameter int          SEP       = 40,
   parameter int          MAX_TRIES = 64,
   parameter int          FB_X      = 200,
   parameter int          FB_Y      = 150,
   parameter int          LVL1      = 5,
   parameter int          LVL2      = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       drive,
   output logic [9:0] box_x,
   output logic [8:0] box_y,
   output logic [7:0] score,
   output logic [1:0] speed_mode,
   output logic       busy,
   output logic       food_new
);

   typedef enum logic {IDLE, GEN} state_t;

   localparam logic [10:0] XMIN_W   = 11'(X_MIN);
   localparam logic [10:0] YMIN_W   = 11'(Y_MIN);
   localparam logic [10:0] XSLOTS_W = 11'(X_SLOTS);
   localparam logic [10:0] YSLOTS_W = 11'(Y_SLOTS);
   localparam logic [10:0] SEP_W    = 11'(SEP);
   localparam logic [7:0]  LAST_TRY = 8'(MAX_TRIES - 1);
   localparam logic [7:0]  LVL1_W   = 8'(LVL1);
   localparam logic [7:0]  LVL2_W   = 8'(LVL2);

   state_t      state;
   logic [15:0] lfsr;
   logic [15:0] lfsr_next;
   logic [7:0]  tries;

   logic [10:0] ix, iy, cx, cy, bx, by, dx, dy;
   logic        slot_ok, near, accept;
   logic [1:0]  speed_next;

   assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // Candidate slot drawn straight from the current LFSR state; 5*i as shift-add.
   assign ix = {3'b000, lfsr[7:0]};
   assign iy = {4'b0000, lfsr[15:9]};
   assign cx = XMIN_W + (ix << 2) + ix;
   assign cy = YMIN_W + (iy << 2) + iy;
   assign bx = {1'b0, box_x};
   assign by = {2'b00, box_y};
   assign dx = (cx > bx) ? (cx - bx) : (bx - cx);
   assign dy = (cy > by) ? (cy - by) : (by - cy);

   assign slot_ok = (ix < XSLOTS_W) && (iy < YSLOTS_W);
   assign near    = (dx < SEP_W) && (dy < SEP_W);
   assign accept  = slot_ok && !near;

   assign speed_next = (score < LVL1_W) ? 2'b00 :
                       (score < LVL2_W) ? 2'b01 : 2'b10;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lfsr       <= SEED;
         tries      <= 8'd0;
         box_x      <= 10'(INIT_X);
         box_y      <= 9'(INIT_Y);
         score      <= 8'd0;
         speed_mode <= 2'b00;
         busy       <= 1'b0;
         food_new   <= 1'b0;
      end else begin
         lfsr       <= lfsr_next;
         food_new   <= 1'b0;
         speed_mode <= speed_next;
         case (state)
            IDLE: begin
               if (drive) begin
                  state <= GEN;
                  busy  <= 1'b1;
                  tries <= 8'd0;
                  if (score != 8'hFF) score <= score + 8'd1;
               end
            end
            GEN: begin
               // drive is deliberately ignored here: repeat eaten pulses are dropped
               if (accept) begin
                  box_x    <= cx[9:0];
                  box_y    <= cy[8:0];
                  food_new <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (tries == LAST_TRY) begin
                  box_x    <= 10'(FB_X);
                  box_y    <= 9'(FB_Y);
                  food_new <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  tries <= tries + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/food_spawner.md
# food_spawner

Places the food box that the snake controller chases and reacts to its eaten pulse. On each accepted `drive` pulse it increments a saturating score. It then searches a free-running 16-bit LFSR for a new on-grid food position away from the old one, and publishes `box_x`/`box_y`. It also derives `speed_mode` from the score. The block sits directly upstream of the snake controller and consumes that controller's `drive` output.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `INIT_X`, 600: box_x after reset.
- `INIT_Y`, 450: box_y after reset.
- `X_MIN`, 20: x of grid slot 0.
- `Y_MIN`, 20: y of grid slot 0.
- `X_SLOTS`, 153: legal x slot indices are 0..X_SLOTS-1 (x max 780).
- `Y_SLOTS`, 97: legal y slot indices are 0..Y_SLOTS-1 (y max 500).
- `SEP`, 40: exclusion half-width around the previous box.
- `MAX_TRIES`, 64: candidates examined before fallback.
- `FB_X`, 200 / `FB_Y`, 150: fallback position.
- `LVL1`, 5 / `LVL2`, 10: score thresholds for speed steps.
- `clk`, in, 1: system clock (the one clock).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `drive`, in, 1: eaten pulse from the snake controller.
- `box_x`, out, 10: food centre x.
- `box_y`, out, 9: food centre y.
- `score`, out, 8: foods eaten, saturates at 255.
- `speed_mode`, out, 2: 00 slowest, 01 slow, 10 normal; 11 is never driven.
- `busy`, out, 1: high while searching.
- `food_new`, out, 1: one-cycle pulse when a new position is committed.

## Operation
- LFSR: Galois right-shift, mask 16'hB400 (x^16+x^14+x^13+x^11+1). Each cycle it does `lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0)`. It advances every cycle regardless of state.
- Candidate from the current LFSR value: `ix = lfsr[7:0]`, `iy = lfsr[15:9]`.
  - `cx = X_MIN + 5*ix` and `cy = Y_MIN + 5*iy`, with `5*i` computed as `(i<<2)+i`.
  - Computed at 11 bits, then truncated to port widths.
- Candidate acceptance requires all of:
  - `ix < X_SLOTS`;
  - `iy < Y_SLOTS`;
  - NOT (`|cx-box_x| < SEP` AND `|cy-box_y| < SEP`). Absolute differences are unsigned, computed as larger minus smaller.
- FSM states:
  - IDLE: when `drive`=1, go to GEN, set `score <= sat(score+1)`, clear the try counter.
  - GEN: evaluate the candidate every cycle.
    - Accepted: load `box_x/box_y <= cx/cy`, assert `food_new` next cycle, go to IDLE.
    - Rejected with tries == MAX_TRIES-1: load `FB_X/FB_Y` (no exclusion check), assert `food_new`, go to IDLE.
    - Otherwise: tries+1, stay in GEN.
- `drive` while in GEN is ignored: no score change, no restart. The controller's repeat pulses while its head still overlaps the old box are therefore dropped.
- `speed_mode` is registered from the updated score:
  - 00 when score < LVL1;
  - 01 when LVL1 ≤ score < LVL2;
  - 10 when score ≥ LVL2.
- `busy` = (state == GEN), registered.

## Timing
- Reset values:
  - `box_x`=INIT_X, `box_y`=INIT_Y;
  - `score`=0, `speed_mode`=00;
  - `busy`=0, `food_new`=0;
  - `lfsr`=SEED, state IDLE, tries=0.
- Latency:
  - `drive` sampled high at edge k: `score` and `busy` update at edge k.
  - First candidate is evaluated during cycle k→k+1.
  - Best case: `box_x/box_y` update at edge k+1 and `food_new` is high for cycle k+1→k+2.
  - Worst case: the box updates at edge k+MAX_TRIES.
- `speed_mode` updates one edge after `score`.
- `busy` falls on the same edge that `box_*` changes.
- `drive` high in the cycle `busy` falls (state already IDLE) is accepted.
- `score` at 255 plus a `drive`: score holds 255 and the search still runs.
- Reset mid-search: outputs return to reset values immediately (asynchronous); no `food_new` is emitted.

## Test plan
- Reset, hold 5 cycles → `box`=(600,450), `score`=0, `speed_mode`=00, `busy`=0, `food_new`=0. The LFSR model matches 16'hACE1 advanced once per cycle.
- Single `drive` pulse → `score`=1. New `box` equals the first accepted candidate of the software LFSR model. `cx` and `cy` are ≡0 mod 5 with 20≤cx≤780 and 20≤cy≤500. `food_new` is exactly one cycle.
- 10 spaced `drive` pulses → `speed_mode` becomes 01 one cycle after score=5 and 10 one cycle after score=10. Every new box lies outside the ±40 square of its predecessor.
- `drive` held high for 8 cycles from IDLE → `score` increments by 1 for the first cycle. Further increments occur only on cycles where the state is IDLE; all match the model.
- Override `X_SLOTS`=0, `MAX_TRIES`=4, then pulse `drive` → `busy` for 4 cycles, `box`=(200,150), one `food_new`.
- Assert `rst_n` low 2 cycles into a GEN with `X_SLOTS`=0 → immediate `box`=(600,450), `busy`=0, `score`=0, no `food_new` after release.
